// File: rtl/dcache_controller.sv
// Direct-mapped write-back data cache between a CPU load/store port and a block-wide memory.
// A miss writes back a dirty victim, refills the line, then replays the held request as a hit.
module dcache_controller #(
  parameter int TAG_W    = 3,
  parameter int INDEX_W  = 3,
  parameter int OFFSET_W = 2,
  parameter int DATA_W   = 8,
  localparam int ADDR_W  = TAG_W + INDEX_W + OFFSET_W,
  localparam int BLOCK_W = DATA_W << OFFSET_W
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic                     read,
  input  logic                     write,
  input  logic [ADDR_W-1:0]        address,
  input  logic [DATA_W-1:0]        writedata,
  output logic [DATA_W-1:0]        readdata,
  output logic                     busywait,
  output logic                     mem_read,
  output logic                     mem_write,
  output logic [TAG_W+INDEX_W-1:0] mem_address,
  output logic [BLOCK_W-1:0]       mem_writedata,
  input  logic [BLOCK_W-1:0]       mem_readdata,
  input  logic                     mem_busywait,
  output logic [1:0]               dbg_state
);

  localparam int LINES = 1 << INDEX_W;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    MEM_WRITE = 2'd1,
    MEM_READ  = 2'd2,
    UPDATE    = 2'd3
  } state_t;

  state_t               state_q, state_d;
  logic                 seen_busy_q, seen_busy_d;
  logic [LINES-1:0]     valid_q, dirty_q;
  logic [TAG_W-1:0]     tag_q  [LINES];
  logic [BLOCK_W-1:0]   data_q [LINES];

  logic [TAG_W-1:0]     addr_tag;
  logic [INDEX_W-1:0]   addr_idx;
  logic [OFFSET_W-1:0]  addr_off;
  logic                 hit;
  logic                 cpu_wr_en;
  logic                 fill_en;
  logic [DATA_W-1:0]    sel_byte;

  assign addr_tag  = address[ADDR_W-1 -: TAG_W];
  assign addr_idx  = address[OFFSET_W +: INDEX_W];
  assign addr_off  = address[OFFSET_W-1:0];
  assign hit       = valid_q[addr_idx] && (tag_q[addr_idx] == addr_tag);
  assign sel_byte  = data_q[addr_idx][int'(addr_off)*DATA_W +: DATA_W];
  assign dbg_state = state_q;

  // Handshakes: the CPU holds read/write (and address) until it sees busywait low, and the
  // access completes in that cycle. Toward memory, mem_read/mem_write stay high until
  // mem_busywait has been seen high and then observed low at a clock edge.
  always_comb begin
    state_d       = state_q;
    busywait      = 1'b0;
    mem_read      = 1'b0;
    mem_write     = 1'b0;
    mem_address   = '0;
    mem_writedata = '0;
    readdata      = '0;
    cpu_wr_en     = 1'b0;
    fill_en       = 1'b0;
    case (state_q)
      IDLE: begin
        if (read || write) begin
          if (hit) begin
            if (write) cpu_wr_en = 1'b1;
            else       readdata  = sel_byte;
          end else begin
            busywait = 1'b1;
            state_d  = (valid_q[addr_idx] && dirty_q[addr_idx]) ? MEM_WRITE : MEM_READ;
          end
        end
      end
      MEM_WRITE: begin
        busywait      = 1'b1;
        mem_write     = 1'b1;
        mem_address   = {tag_q[addr_idx], addr_idx};
        mem_writedata = data_q[addr_idx];
        if (seen_busy_q && !mem_busywait) state_d = MEM_READ;
      end
      MEM_READ: begin
        busywait    = 1'b1;
        mem_read    = 1'b1;
        mem_address = {addr_tag, addr_idx};
        if (seen_busy_q && !mem_busywait) state_d = UPDATE;
      end
      UPDATE: begin
        busywait = 1'b1;
        fill_en  = 1'b1;
        state_d  = IDLE;
      end
      default: state_d = IDLE;
    endcase
    // Remembers that the current transfer has started; cleared on every state change.
    seen_busy_d = ((state_q == MEM_WRITE) || (state_q == MEM_READ)) &&
                  (state_d == state_q) && (seen_busy_q || mem_busywait);
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q     <= IDLE;
      seen_busy_q <= 1'b0;
      valid_q     <= '0;
      dirty_q     <= '0;
    end else begin
      state_q     <= state_d;
      seen_busy_q <= seen_busy_d;
      if (fill_en) begin
        valid_q[addr_idx] <= 1'b1;
        dirty_q[addr_idx] <= 1'b0;
      end else if (cpu_wr_en) begin
        dirty_q[addr_idx] <= 1'b1;
      end
    end
  end

  // Tags and data are qualified by valid, so they carry no reset.
  always_ff @(posedge clock) begin
    if (fill_en) begin
      data_q[addr_idx] <= mem_readdata;
      tag_q[addr_idx]  <= addr_tag;
    end else if (cpu_wr_en) begin
      data_q[addr_idx][int'(addr_off)*DATA_W +: DATA_W] <= writedata;
    end
  end

endmodule

// File: tb/tb_dcache_controller.sv
// Directed bench for dcache_controller: hits, clean and dirty misses, async reset mid-refill,
// write-allocate and a request dropped during a miss, against a block memory model.
module tb_dcache_controller;

  logic        clock = 1'b0;
  logic        reset;
  logic        read, write;
  logic [7:0]  address;
  logic [7:0]  writedata;
  logic [7:0]  readdata;
  logic        busywait;
  logic        mem_read, mem_write;
  logic [5:0]  mem_address;
  logic [31:0] mem_writedata;
  logic [31:0] mem_readdata = '0;
  logic        mem_busywait = 1'b0;
  logic [1:0]  dbg_state;

  int checks   = 0;
  int failures = 0;

  always #5 clock = ~clock;

  dcache_controller dut (
    .clock         (clock),
    .reset         (reset),
    .read          (read),
    .write         (write),
    .address       (address),
    .writedata     (writedata),
    .readdata      (readdata),
    .busywait      (busywait),
    .mem_read      (mem_read),
    .mem_write     (mem_write),
    .mem_address   (mem_address),
    .mem_writedata (mem_writedata),
    .mem_readdata  (mem_readdata),
    .mem_busywait  (mem_busywait),
    .dbg_state     (dbg_state)
  );

  // ---------------- memory model: 5 busy cycles per block transfer ----------------
  logic [31:0] wmem [64];
  logic [63:0] wvalid = '0;
  logic [1:0]  last_req = 2'b00;
  int          mcnt = 0;

  function automatic logic [31:0] mem_init(input logic [5:0] a);
    case (a)
      6'h09:   mem_init = 32'hDDCCBBAA;
      6'h11:   mem_init = 32'h44332211;
      6'h02:   mem_init = 32'h0F0E0D0C;
      6'h0A:   mem_init = 32'hA3A2A1A0;
      default: mem_init = {4{2'b00, a}};
    endcase
  endfunction

  function automatic logic [31:0] mem_rd(input logic [5:0] a);
    mem_rd = wvalid[a] ? wmem[a] : mem_init(a);
  endfunction

  always @(posedge clock) begin
    if ({mem_read, mem_write} == 2'b00) begin
      mem_busywait <= 1'b0;
      mcnt         <= 0;
    end else if ({mem_read, mem_write} != last_req) begin
      mem_busywait <= 1'b1;
      mcnt         <= 5;
    end else if (mcnt > 1) begin
      mcnt <= mcnt - 1;
    end else if (mcnt == 1) begin
      mem_busywait <= 1'b0;
      mcnt         <= 0;
      if (mem_read) begin
        mem_readdata <= mem_rd(mem_address);
      end else begin
        wmem[mem_address]   <= mem_writedata;
        wvalid[mem_address] <= 1'b1;
      end
    end
    last_req <= {mem_read, mem_write};
  end

  // ---------------- traffic monitor ----------------
  int          cyc = 0;
  int          overlap_n = 0;
  int          mw_n = 0, mr_n = 0;
  int          wb_at = 0, rd_at = 0;
  logic [5:0]  wb_addr, rd_addr;
  logic [31:0] wb_data;

  always @(negedge clock) begin
    if (mem_read && mem_write) overlap_n++;
    if (mem_write) begin
      if (mw_n == 0) begin
        wb_addr = mem_address;
        wb_data = mem_writedata;
        wb_at   = cyc;
      end
      mw_n++;
    end
    if (mem_read) begin
      if (mr_n == 0) begin
        rd_addr = mem_address;
        rd_at   = cyc;
      end
      mr_n++;
    end
    cyc++;
  end

  task automatic clear_log();
    overlap_n = 0;
    mw_n      = 0;
    mr_n      = 0;
  endtask

  // Polls each falling edge until busywait drops; n == 200 means the bound expired.
  task automatic wait_ready(output int n);
    n = 0;
    do begin
      @(negedge clock);
      #1;
      n++;
    end while (busywait && n < 200);
  endtask

  task automatic cpu_idle();
    read      = 1'b0;
    write     = 1'b0;
    writedata = 8'h00;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    reset = 1'b0;
    cpu_idle();
    address = 8'h00;
    #1;
    checks++; if (busywait !== 1'b0) begin failures++; $display("FAIL reset_busywait got=%b exp=0", busywait); end
    checks++; if ({mem_read, mem_write} !== 2'b00) begin failures++; $display("FAIL reset_mem_req got=%b exp=00", {mem_read, mem_write}); end
    checks++; if (readdata !== 8'h00) begin failures++; $display("FAIL reset_readdata got=%h exp=00", readdata); end
    checks++; if (dbg_state !== 2'd0) begin failures++; $display("FAIL reset_state got=%0d exp=0", dbg_state); end
    checks++; if (dut.valid_q !== 8'h00) begin failures++; $display("FAIL reset_valid got=%h exp=00", dut.valid_q); end
    @(negedge clock);
    @(negedge clock);
    reset = 1'b1;
  endtask

  task automatic test_read_miss_clean();
    int n;
    @(negedge clock);
    clear_log();
    read    = 1'b1;
    address = 8'h25;
    #1;
    checks++; if (busywait !== 1'b1) begin failures++; $display("FAIL miss_busywait_same_cycle got=%b exp=1", busywait); end
    @(negedge clock);
    #1;
    checks++; if (mem_read !== 1'b1) begin failures++; $display("FAIL miss_mem_read got=%b exp=1", mem_read); end
    checks++; if (mem_address !== 6'h09) begin failures++; $display("FAIL miss_mem_address got=%h exp=09", mem_address); end
    wait_ready(n);
    n = n + 1;
    checks++; if (n != 9) begin failures++; $display("FAIL miss_latency got=%0d exp=9", n); end
    checks++; if (readdata !== 8'hBB) begin failures++; $display("FAIL miss_readdata got=%h exp=BB", readdata); end
    checks++; if (dut.valid_q[1] !== 1'b1) begin failures++; $display("FAIL miss_valid1 got=%b exp=1", dut.valid_q[1]); end
    checks++; if (mw_n != 0) begin failures++; $display("FAIL miss_clean_no_writeback got=%0d exp=0", mw_n); end
    @(negedge clock);
    cpu_idle();
  endtask

  task automatic test_read_hit();
    @(negedge clock);
    clear_log();
    read    = 1'b1;
    address = 8'h24;
    #1;
    checks++; if (busywait !== 1'b0) begin failures++; $display("FAIL hit_busywait got=%b exp=0", busywait); end
    checks++; if (readdata !== 8'hAA) begin failures++; $display("FAIL hit_readdata got=%h exp=AA", readdata); end
    @(negedge clock);
    cpu_idle();
    #1;
    checks++; if (mr_n != 0) begin failures++; $display("FAIL hit_no_mem_read got=%0d exp=0", mr_n); end
  endtask

  task automatic test_write_hit();
    @(negedge clock);
    clear_log();
    write     = 1'b1;
    address   = 8'h27;
    writedata = 8'h5A;
    #1;
    checks++; if (busywait !== 1'b0) begin failures++; $display("FAIL whit_busywait got=%b exp=0", busywait); end
    @(negedge clock);
    cpu_idle();
    read    = 1'b1;
    address = 8'h27;
    #1;
    checks++; if (readdata !== 8'h5A) begin failures++; $display("FAIL whit_readback got=%h exp=5A", readdata); end
    checks++; if (dut.data_q[1] !== 32'h5ACCBBAA) begin failures++; $display("FAIL whit_line got=%h exp=5ACCBBAA", dut.data_q[1]); end
    checks++; if (dut.dirty_q[1] !== 1'b1) begin failures++; $display("FAIL whit_dirty got=%b exp=1", dut.dirty_q[1]); end
    @(negedge clock);
    cpu_idle();
    checks++; if (mw_n + mr_n != 0) begin failures++; $display("FAIL whit_no_traffic got=%0d exp=0", mw_n + mr_n); end
  endtask

  task automatic test_dirty_conflict();
    int n;
    @(negedge clock);
    clear_log();
    read    = 1'b1;
    address = 8'h45;
    wait_ready(n);
    checks++; if (n >= 200) begin failures++; $display("FAIL evict_timeout got=%0d exp<200", n); end
    checks++; if (wb_addr !== 6'h09) begin failures++; $display("FAIL evict_wb_addr got=%h exp=09", wb_addr); end
    checks++; if (wb_data !== 32'h5ACCBBAA) begin failures++; $display("FAIL evict_wb_data got=%h exp=5ACCBBAA", wb_data); end
    checks++; if (rd_addr !== 6'h11) begin failures++; $display("FAIL evict_rd_addr got=%h exp=11", rd_addr); end
    checks++; if (!(mw_n > 0 && mr_n > 0 && wb_at < rd_at)) begin failures++; $display("FAIL evict_order got wb_at=%0d rd_at=%0d exp wb_at<rd_at", wb_at, rd_at); end
    checks++; if (overlap_n != 0) begin failures++; $display("FAIL evict_overlap got=%0d exp=0", overlap_n); end
    checks++; if (readdata !== 8'h22) begin failures++; $display("FAIL evict_readdata got=%h exp=22", readdata); end
    checks++; if (mem_rd(6'h09) !== 32'h5ACCBBAA) begin failures++; $display("FAIL evict_mem_content got=%h exp=5ACCBBAA", mem_rd(6'h09)); end
    @(negedge clock);
    cpu_idle();
  endtask

  task automatic test_reset_mid_miss();
    int n;
    @(negedge clock);
    read    = 1'b1;
    address = 8'h85;
    @(negedge clock);
    @(negedge clock);
    @(negedge clock);
    #1;
    checks++; if (mem_read !== 1'b1) begin failures++; $display("FAIL rst_pre_mem_read got=%b exp=1", mem_read); end
    #1;
    cpu_idle();
    reset = 1'b0;
    #1;
    checks++; if (busywait !== 1'b0) begin failures++; $display("FAIL rst_busywait got=%b exp=0", busywait); end
    checks++; if (mem_read !== 1'b0) begin failures++; $display("FAIL rst_mem_read got=%b exp=0", mem_read); end
    checks++; if (dut.valid_q !== 8'h00) begin failures++; $display("FAIL rst_valid got=%h exp=00", dut.valid_q); end
    @(negedge clock);
    reset = 1'b1;
    @(negedge clock);
    clear_log();
    read    = 1'b1;
    address = 8'h24;
    #1;
    checks++; if (busywait !== 1'b1) begin failures++; $display("FAIL rst_after_miss got=%b exp=1", busywait); end
    wait_ready(n);
    checks++; if (rd_addr !== 6'h09) begin failures++; $display("FAIL rst_refill_addr got=%h exp=09", rd_addr); end
    checks++; if (readdata !== 8'hAA) begin failures++; $display("FAIL rst_refill_data got=%h exp=AA", readdata); end
    @(negedge clock);
    cpu_idle();
  endtask

  task automatic test_write_miss_clean();
    int n;
    @(negedge clock);
    clear_log();
    write     = 1'b1;
    address   = 8'h0B;
    writedata = 8'h77;
    #1;
    checks++; if (busywait !== 1'b1) begin failures++; $display("FAIL wmiss_busywait got=%b exp=1", busywait); end
    wait_ready(n);
    checks++; if (n >= 200) begin failures++; $display("FAIL wmiss_timeout got=%0d exp<200", n); end
    @(negedge clock);
    cpu_idle();
    #1;
    checks++; if (dut.data_q[2] !== 32'h770E0D0C) begin failures++; $display("FAIL wmiss_line got=%h exp=770E0D0C", dut.data_q[2]); end
    checks++; if (dut.dirty_q[2] !== 1'b1) begin failures++; $display("FAIL wmiss_dirty got=%b exp=1", dut.dirty_q[2]); end
    checks++; if (mw_n != 0) begin failures++; $display("FAIL wmiss_no_writeback got=%0d exp=0", mw_n); end
  endtask

  task automatic test_drop_mid_miss();
    int n;
    @(negedge clock);
    clear_log();
    write     = 1'b1;
    address   = 8'h2A;
    writedata = 8'h99;
    @(negedge clock);
    @(negedge clock);
    write = 1'b0;
    n = 0;
    do begin
      @(negedge clock);
      #1;
      n++;
    end while (dbg_state != 2'd0 && n < 200);
    checks++; if (n >= 200) begin failures++; $display("FAIL drop_timeout got=%0d exp<200", n); end
    @(negedge clock);
    #1;
    checks++; if (mem_rd(6'h02) !== 32'h770E0D0C) begin failures++; $display("FAIL drop_writeback got=%h exp=770E0D0C", mem_rd(6'h02)); end
    checks++; if (dut.data_q[2] !== 32'hA3A2A1A0) begin failures++; $display("FAIL drop_no_cpu_write got=%h exp=A3A2A1A0", dut.data_q[2]); end
    checks++; if (dut.dirty_q[2] !== 1'b0) begin failures++; $display("FAIL drop_dirty got=%b exp=0", dut.dirty_q[2]); end
  endtask

  task automatic test_back_to_back();
    logic [7:0] exp_b [4];
    exp_b[0] = 8'hA0; exp_b[1] = 8'hA1; exp_b[2] = 8'hA2; exp_b[3] = 8'hA3;
    clear_log();
    for (int k = 0; k < 4; k++) begin
      @(negedge clock);
      read    = 1'b1;
      address = 8'h28 + 8'(k);
      #1;
      checks++; if ({busywait, readdata} !== {1'b0, exp_b[k]}) begin failures++; $display("FAIL b2b_off%0d got bw=%b rd=%h exp bw=0 rd=%h", k, busywait, readdata, exp_b[k]); end
    end
    @(negedge clock);
    cpu_idle();
    checks++; if (mr_n + mw_n != 0) begin failures++; $display("FAIL b2b_no_traffic got=%0d exp=0", mr_n + mw_n); end
  endtask

  initial begin
    test_reset();
    test_read_miss_clean();
    test_read_hit();
    test_write_hit();
    test_dirty_conflict();
    test_reset_mid_miss();
    test_write_miss_clean();
    test_drop_mid_miss();
    test_back_to_back();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
